// File: rtl/scene_renderer.sv
// scene_renderer
// ----------------
// Scales a small indexed-colour image (optionally animated over several
// frames stored back-to-back in ROM) up to a 640x480 VGA raster, looks each
// index up in an external combinational palette, and registers the result.
// An optional fade unit brightens and dims the image in 1/16 steps, one step
// per video frame.
//
// Configuration macro: SCENE_RENDERER_FADE_EN
//   defined   -> fade FSM (HIDDEN / FADE_IN / SHOWN / FADE_OUT) scales colour
//   undefined -> no FSM, full brightness, show ignored, fade_busy tied 0
//
// Ports
//   vga_clk        in   sole clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   DrawX, DrawY   in   current pixel coordinate (0..639, 0..479)
//   blank          in   1 = active video
//   show           in   request image visible (fade build only)
//   anim_en        in   enable animation stepping
//   rom_addr       out  registered image ROM address
//   rom_q          in   ROM data, ROM_LAT edges after rom_addr
//   pal_index      out  palette index (= rom_q)
//   pal_red/green/blue in combinational palette colour for pal_index
//   red/green/blue out  registered pixel colour, ROM_LAT+2 edges after input
//   frame_sel      out  current animation frame
//   fade_busy      out  1 while fading in or out
//   dbg_fade_state out  fade FSM state (0 HIDDEN, 1 FADE_IN, 2 SHOWN, 3 FADE_OUT)
//
// Pipeline, counted from the edge that samples DrawX/DrawY/blank (edge k):
//   k          rom_addr registered
//   k+ROM_LAT  rom_q valid (external ROM)
//   k+ROM_LAT+1 palette colour registered
//   k+ROM_LAT+2 scaled, blank-gated colour registered on red/green/blue
module scene_renderer #(
    parameter int IMG_W      = 105,
    parameter int IMG_H      = 66,
    parameter int NUM_FRAMES = 4,
    parameter int INDEX_W    = 4,
    parameter int ADDR_W     = 15,
    parameter int ROM_LAT    = 1,
    parameter int ANIM_DIV   = 8,
    localparam int FRAME_W   = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic               blank,
    input  logic               show,
    input  logic               anim_en,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INDEX_W-1:0] rom_q,
    output logic [INDEX_W-1:0] pal_index,
    input  logic [3:0]         pal_red,
    input  logic [3:0]         pal_green,
    input  logic [3:0]         pal_blue,
    output logic [3:0]         red,
    output logic [3:0]         green,
    output logic [3:0]         blue,
    output logic [FRAME_W-1:0] frame_sel,
    output logic               fade_busy,
    output logic [1:0]         dbg_fade_state
);

    localparam int CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic [ROM_LAT+1:0] blank_q, blank_d;   // blank delayed alongside the data
    logic [11:0]        pal_c_q, pal_c_d;
    logic [11:0]        rgb_q, rgb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               frame_strobe;

    // One-cycle strobe on the pixel that opens each video frame.
    assign frame_strobe = (DrawX == 10'd0) && (DrawY == 10'd0);

    always_comb begin
        rom_addr_d = ADDR_W'((32'(DrawX) * 32'(IMG_W)) / 32'd640
                             + ((32'(DrawY) * 32'(IMG_H)) / 32'd480) * 32'(IMG_W)
                             + 32'(frame_q) * 32'(IMG_W) * 32'(IMG_H));
        blank_d    = {blank_q[ROM_LAT:0], blank};
        pal_c_d    = {pal_red, pal_green, pal_blue};
    end

    // Animation: count strobes while enabled, advance one frame per ANIM_DIV.
    // With a single frame the wrap compare is always true, pinning frame 0.
    always_comb begin
        cnt_d   = cnt_q;
        frame_d = frame_q;
        if (frame_strobe && anim_en) begin
            if (cnt_q == CNT_W'(ANIM_DIV - 1)) begin
                cnt_d   = '0;
                frame_d = (frame_q == FRAME_W'(NUM_FRAMES - 1)) ? '0
                                                                : frame_q + FRAME_W'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

`ifdef SCENE_RENDERER_FADE_EN
    // ------------------------------------------------------------------
    // Fade FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        HIDDEN   = 2'd0,
        FADE_IN  = 2'd1,
        SHOWN    = 2'd2,
        FADE_OUT = 2'd3
    } fade_state_e;

    fade_state_e state_q, state_d;
    logic [4:0]  level_q, level_d;

    function automatic logic [3:0] scale(input logic [3:0] c, input logic [4:0] lvl);
        logic [8:0] p;
        p = {5'd0, c} * {4'd0, lvl};
        return 4'(p >> 4);
    endfunction

    // The level step on a strobe is computed first; the transition then looks
    // at the stepped level. Steps saturate at 0/16 because a direction change
    // between strobes can land in FADE_IN at 16 or FADE_OUT at 0.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        case (state_q)
            HIDDEN: begin
                if (show) state_d = FADE_IN;
            end
            FADE_IN: begin
                if (frame_strobe && (level_q != 5'd16)) level_d = level_q + 5'd1;
                if (!show)                  state_d = FADE_OUT;
                else if (level_d == 5'd16)  state_d = SHOWN;
            end
            SHOWN: begin
                if (!show) state_d = FADE_OUT;
            end
            FADE_OUT: begin
                if (frame_strobe && (level_q != 5'd0)) level_d = level_q - 5'd1;
                if (show)                   state_d = FADE_IN;
                else if (level_d == 5'd0)   state_d = HIDDEN;
            end
            default: begin
                state_d = HIDDEN;
            end
        endcase
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= HIDDEN;
            level_q <= 5'd0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
        end
    end

    assign fade_busy      = (state_q == FADE_IN) || (state_q == FADE_OUT);
    assign dbg_fade_state = state_q;

    always_comb begin
        rgb_d = '0;
        if (blank_q[ROM_LAT+1]) begin
            rgb_d = {scale(pal_c_q[11:8], level_q),
                     scale(pal_c_q[7:4],  level_q),
                     scale(pal_c_q[3:0],  level_q)};
        end
    end
`else
    // Full brightness: colour is the registered palette colour gated by blank.
    logic unused_show;
    assign unused_show    = show;
    assign fade_busy      = 1'b0;
    assign dbg_fade_state = 2'd2;

    always_comb begin
        rgb_d = '0;
        if (blank_q[ROM_LAT+1]) rgb_d = pal_c_q;
    end
`endif

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr_q <= '0;
            blank_q    <= '0;
            pal_c_q    <= '0;
            rgb_q      <= '0;
            cnt_q      <= '0;
            frame_q    <= '0;
        end else begin
            rom_addr_q <= rom_addr_d;
            blank_q    <= blank_d;
            pal_c_q    <= pal_c_d;
            rgb_q      <= rgb_d;
            cnt_q      <= cnt_d;
            frame_q    <= frame_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign pal_index = rom_q;
    assign red       = rgb_q[11:8];
    assign green     = rgb_q[7:4];
    assign blue      = rgb_q[3:0];
    assign frame_sel = frame_q;

endmodule

// File: tb/tb_scene_renderer.sv
// Testbench for scene_renderer. Models a ROM_LAT=2 ROM and a small palette;
// every driven pixel pushes its expected colour to exp_q, and the monitor pops
// one entry per output pixel, ROM_LAT+2 edges after the pixel was sampled.
module tb_scene_renderer;

    localparam int IMG_W      = 105;
    localparam int IMG_H      = 66;
    localparam int NUM_FRAMES = 4;
    localparam int INDEX_W    = 4;
    localparam int ADDR_W     = 15;
    localparam int ROM_LAT    = 2;
    localparam int ANIM_DIV   = 8;
    localparam int LAT        = ROM_LAT + 2;

`ifdef SCENE_RENDERER_FADE_EN
    localparam logic [1:0] RST_STATE = 2'd0;
`else
    localparam logic [1:0] RST_STATE = 2'd2;
`endif

    logic               vga_clk;
    logic               reset_n;
    logic [9:0]         DrawX, DrawY;
    logic               blank, show, anim_en;
    logic [ADDR_W-1:0]  rom_addr;
    logic [INDEX_W-1:0] rom_q;
    logic [INDEX_W-1:0] pal_index;
    logic [3:0]         pal_red, pal_green, pal_blue;
    logic [3:0]         red, green, blue;
    logic [1:0]         frame_sel;
    logic               fade_busy;
    logic [1:0]         dbg_fade_state;

    scene_renderer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .NUM_FRAMES(NUM_FRAMES), .INDEX_W(INDEX_W),
        .ADDR_W(ADDR_W), .ROM_LAT(ROM_LAT), .ANIM_DIV(ANIM_DIV)
    ) dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .show(show), .anim_en(anim_en), .rom_addr(rom_addr),
        .rom_q(rom_q), .pal_index(pal_index), .pal_red(pal_red),
        .pal_green(pal_green), .pal_blue(pal_blue), .red(red), .green(green),
        .blue(blue), .frame_sel(frame_sel), .fade_busy(fade_busy),
        .dbg_fade_state(dbg_fade_state)
    );

    // ---------------- clock / reset ----------------
    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- ROM and palette models ----------------
    function automatic logic [3:0] rom_f(input logic [14:0] a);
        return a[3:0] ^ a[7:4] ^ a[11:8] ^ {1'b0, a[14:12]};
    endfunction

    function automatic logic [11:0] pal_f(input logic [3:0] idx, input logic force_f);
        if (force_f) return 12'hFFF;
        return {idx, idx ^ 4'hA, ~idx};
    endfunction

    logic [ADDR_W-1:0] rom_a1;
    logic              pal_force;

    always @(posedge vga_clk) begin
        rom_a1 <= rom_addr;
        rom_q  <= rom_f(rom_a1);
    end

    always_comb begin
        {pal_red, pal_green, pal_blue} = pal_f(pal_index, pal_force);
    end

    // ---------------- scoreboard state ----------------
    logic [11:0] exp_q[$];
    int          n_checks;
    int          n_errors;
    int          exp_level;
    int          exp_frame;
    int          strobe_cnt;
    logic        drv_valid;
    logic [LAT:0] vpipe;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_addr(input int x, input int y, input int f);
        return (x * IMG_W) / 640 + ((y * IMG_H) / 480) * IMG_W + f * IMG_W * IMG_H;
    endfunction

    function automatic logic [11:0] exp_rgb(input int x, input int y, input logic b,
                                            input int f, input int lvl);
        logic [11:0] p;
        int r, g, bl;
        if (!b) return 12'h000;
        p  = pal_f(rom_f(15'(exp_addr(x, y, f))), pal_force);
        r  = (int'(p[11:8]) * lvl) >> 4;
        g  = (int'(p[7:4])  * lvl) >> 4;
        bl = (int'(p[3:0])  * lvl) >> 4;
        return {4'(r), 4'(g), 4'(bl)};
    endfunction

    // Tracks which cycles carry a pushed pixel, so the monitor knows when to pop.
    always @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) vpipe <= '0;
        else          vpipe <= {vpipe[LAT-1:0], drv_valid};
    end

    always @(negedge vga_clk) begin
        if (drv_valid) check("pal_index", pal_index, rom_q);
        if (vpipe[LAT]) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 0, 1);
            end else begin
                check("rgb", {red, green, blue}, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_px(input int x, input int y, input logic b);
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = b;
        exp_q.push_back(exp_rgb(x, y, b, exp_frame, exp_level));
        drv_valid = 1'b1;
        @(posedge vga_clk);
        #1;
        check("rom_addr", rom_addr, exp_addr(x, y, exp_frame));
        if (x == 0 && y == 0 && anim_en) begin
            strobe_cnt++;
            if (strobe_cnt == ANIM_DIV) begin
                strobe_cnt = 0;
                exp_frame  = (exp_frame + 1) % NUM_FRAMES;
            end
        end
    endtask

    // Blanked lead-in keeps visible pixels out of flight across the level step.
    task automatic strobe();
        for (int i = 0; i < LAT; i++) drive_px(2 + i, 1, 1'b0);
        drive_px(0, 0, 1'b0);
    endtask

    task automatic vis(input int n);
        for (int i = 0; i < n; i++)
            drive_px($urandom_range(1, 639), $urandom_range(0, 479), 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < LAT + 1; i++) drive_px(1, 1, 1'b0);
    endtask

    task automatic async_reset();
        drv_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_rgb", {red, green, blue}, 12'h000);
        check("rst_addr", rom_addr, 0);
        check("rst_frame", frame_sel, 0);
        check("rst_busy", fade_busy, 0);
        check("rst_state", dbg_fade_state, RST_STATE);
        exp_q.delete();
        exp_frame  = 0;
        strobe_cnt = 0;
        @(posedge vga_clk);
        #1;
        reset_n = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    int anim_n[4];
    logic anim_e[4];
    int seq_exp[4];
    int total_en;

    initial begin
        n_checks = 0; n_errors = 0;
        exp_frame = 0; strobe_cnt = 0; total_en = 0;
        drv_valid = 1'b0; pal_force = 1'b0;
        reset_n = 1'b0; DrawX = '0; DrawY = '0; blank = 1'b0;
        show = 1'b0; anim_en = 1'b0;
`ifdef SCENE_RENDERER_FADE_EN
        exp_level = 0;
`else
        exp_level = 16;
`endif
        repeat (3) @(posedge vga_clk);
        #1;
        check("reset_rgb", {red, green, blue}, 12'h000);
        check("reset_addr", rom_addr, 0);
        check("reset_frame", frame_sel, 0);
        check("reset_busy", fade_busy, 0);
        check("reset_state", dbg_fade_state, RST_STATE);
        reset_n = 1'b1;

`ifdef SCENE_RENDERER_FADE_EN
        // Fade in from HIDDEN with a white palette: red = level-1 per step.
        pal_force = 1'b1;
        vis(3);
        show = 1'b1;
        drive_px(1, 1, 1'b0);
        check("fadein_state", dbg_fade_state, 2'd1);
        check("fadein_busy", fade_busy, 1);
        for (int i = 1; i <= 16; i++) begin
            strobe();
            exp_level = i;
            vis(3);
            check("fadein_busy_step", fade_busy, (i < 16) ? 1 : 0);
        end
        check("shown_state", dbg_fade_state, 2'd2);
        drain();
        pal_force = 1'b0;
`endif

        // Bottom-right corner maps to the last image pixel of frame 0.
        drive_px(639, 479, 1'b1);
        check("addr_corner", rom_addr, 6929);

        // Single visible pixel between blanked ones.
        for (int i = 0; i < 3; i++) drive_px(1, 1, 1'b0);
        drive_px(320, 240, 1'b1);
        for (int i = 0; i < LAT + 1; i++) drive_px(1, 1, 1'b0);

        for (int i = 0; i < 40; i++)
            drive_px($urandom_range(1, 639), $urandom_range(0, 479), 1'($urandom_range(0, 1)));

`ifndef SCENE_RENDERER_FADE_EN
        show = 1'b1;
        vis(4);
        check("noshow_busy", fade_busy, 0);
        show = 1'b0;
        vis(4);
        check("noshow_busy2", fade_busy, 0);
`endif

        // Animation: 32 strobes give 1,2,3,0; then a hold, then resume.
        anim_n = '{32, 12, 10, 4};
        anim_e = '{1'b1, 1'b1, 1'b0, 1'b1};
        seq_exp = '{1, 2, 3, 0};
        for (int p = 0; p < 4; p++) begin
            anim_en = anim_e[p];
            for (int s = 1; s <= anim_n[p]; s++) begin
                strobe();
                if (anim_en) total_en++;
                check("frame_sel", frame_sel, exp_frame);
                if (p == 0 && (s % 8) == 0) check("frame_seq", frame_sel, seq_exp[s / 8 - 1]);
                vis(2);
            end
        end
        check("frame_final", frame_sel, 2);
        anim_en = 1'b0;
        drain();

`ifdef SCENE_RENDERER_FADE_EN
        // Fade out from SHOWN.
        pal_force = 1'b1;
        show = 1'b0;
        drive_px(1, 1, 1'b0);
        check("fadeout_state", dbg_fade_state, 2'd3);
        for (int i = 1; i <= 16; i++) begin
            strobe();
            exp_level = 16 - i;
            vis(2);
        end
        check("hidden_state", dbg_fade_state, 2'd0);
        check("hidden_busy", fade_busy, 0);

        // Fade in to 9, reverse, and fade back out from 9.
        show = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            strobe();
            exp_level = i;
            vis(2);
        end
        check("rev_in_state", dbg_fade_state, 2'd1);
        show = 1'b0;
        drive_px(1, 1, 1'b0);
        check("rev_out_state", dbg_fade_state, 2'd3);
        vis(2);
        for (int i = 1; i <= 9; i++) begin
            strobe();
            exp_level = 9 - i;
            vis(2);
            if (i < 9) check("rev_busy", fade_busy, 1);
        end
        check("rev_hidden", dbg_fade_state, 2'd0);
        check("rev_hidden_busy", fade_busy, 0);

        // Reset in the middle of a fade-in.
        show = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            strobe();
            exp_level = i;
            vis(2);
        end
        vis(4);
        async_reset();
        exp_level = 0;
        vis(4);
        for (int i = 1; i <= 3; i++) begin
            strobe();
            exp_level = i;
            vis(3);
        end
        check("post_rst_state", dbg_fade_state, 2'd1);
`else
        vis(4);
        async_reset();
        vis(6);
`endif

        drain();
        drv_valid = 1'b0;
        repeat (LAT + 2) @(posedge vga_clk);
        #1;
        check("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
